// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multi-cycle IEEE-754 single-precision multiplier (shift-add mantissa, RNE, flush denormals)
package fp;
  localparam int EXPONENT_BITS = 8;
  localparam int FRACTION_BITS = 23;
  typedef struct packed {
    logic                     sign;
    logic [EXPONENT_BITS-1:0] exponent;
    logic [FRACTION_BITS-1:0] fraction;
  } float;
endpackage

module fp_mul_seq #(
  parameter int                   EXP_BITS  = fp::EXPONENT_BITS,
  parameter int                   FRAC_BITS = fp::FRACTION_BITS,
  parameter logic [FRAC_BITS-1:0] QNAN_FRAC = 23'h400000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_invalid
);
  if (EXP_BITS != fp::EXPONENT_BITS || FRAC_BITS != fp::FRACTION_BITS) begin : g_chk
    $error("fp_mul_seq: field widths must match the fp package");
  end
  typedef enum logic [1:0] {IDLE, MULT, ROUND, DONE} state_t;
  state_t state, next;
  fp::float a, b;
  logic [4:0] cnt;
  logic sign, sp_inv, sp_inf, sp_zero;
  logic [EXP_BITS-1:0] ea, eb;
  logic [FRAC_BITS:0] ma, mb;
  logic [47:0] acc;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic signed [9:0] e0, e1, e2;
  logic hi, g, s, ovf, unf, to_inf, to_zero;
  logic [22:0] mt;
  logic [23:0] rnd;
  logic [31:0] res;
  assign a = in_a;
  assign b = in_b;
  assign a_nan  = (&a.exponent) & (|a.fraction);
  assign b_nan  = (&b.exponent) & (|b.fraction);
  assign a_inf  = (&a.exponent) & ~(|a.fraction);
  assign b_inf  = (&b.exponent) & ~(|b.fraction);
  assign a_zero = ~(|a.exponent);
  assign b_zero = ~(|b.exponent);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = in_valid ? MULT : IDLE;
      MULT:    next = (cnt == 5'd23) ? ROUND : MULT;
      ROUND:   next = DONE;
      DONE:    next = out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = rst_n & (state == IDLE);
    out_valid = (state == DONE);
  end
  // Normalise the 48-bit product, round to nearest-even, then range-check the exponent
  always_comb begin
    hi      = acc[47];
    mt      = hi ? acc[46:24] : acc[45:23];
    g       = hi ? acc[23] : acc[22];
    s       = hi ? |acc[22:0] : |acc[21:0];
    e0      = 10'(ea) + 10'(eb) - 10'sd127;
    e1      = e0 + 10'(hi);
    rnd     = {1'b0, mt} + 24'(g & (s | mt[0]));
    e2      = e1 + 10'(rnd[23]);
    ovf     = e2 >= 10'sd255;
    unf     = e2 <= 10'sd0;
    to_inf  = sp_inf | (~sp_zero & ovf);
    to_zero = sp_zero | unf;
    res     = sp_inv  ? {1'b0, {EXP_BITS{1'b1}}, QNAN_FRAC} :
              to_inf  ? {sign, {EXP_BITS{1'b1}}, {FRAC_BITS{1'b0}}} :
              to_zero ? {sign, 31'b0} :
                        {sign, e2[7:0], rnd[22:0]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      sign          <= 1'b0;
      sp_inv        <= 1'b0;
      sp_inf        <= 1'b0;
      sp_zero       <= 1'b0;
      ea            <= '0;
      eb            <= '0;
      ma            <= '0;
      mb            <= '0;
      acc           <= '0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_invalid   <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        sign    <= a.sign ^ b.sign;
        ea      <= a.exponent;
        eb      <= b.exponent;
        ma      <= a_zero ? '0 : {1'b1, a.fraction};
        mb      <= b_zero ? '0 : {1'b1, b.fraction};
        sp_inv  <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        sp_inf  <= a_inf | b_inf;
        sp_zero <= a_zero | b_zero;
        cnt     <= '0;
        acc     <= '0;
      end
      if (state == MULT) begin
        acc <= acc + (mb[0] ? (48'(ma) << cnt) : 48'd0);
        mb  <= mb >> 1;
        cnt <= cnt + 5'd1;
      end
      if (state == ROUND) begin
        out_result    <= res;
        out_overflow  <= ~sp_inv & ~sp_inf & ~sp_zero & ovf;
        out_underflow <= ~sp_inv & ~sp_inf & ~sp_zero & ~ovf & unf;
        out_invalid   <= sp_inv;
      end
    end
  end
endmodule
